// File: rtl/irq_pending_ctrl.sv
// irq_pending_ctrl: latches 8 request lines into a pending vector and presents
// the highest-priority eligible one (bit 7 first) until acknowledged or timed out.
// Optional feature macro: IRQ_MASK_EN adds the per-request mask port.
// Ports:
//   clk         - single clock, rising edge
//   rst_n       - synchronous active-low reset
//   req[7:0]    - request lines, sampled every cycle
//   ack         - consumer acknowledge of the presented request
//   mask[7:0]   - per-request disable, 1 = masked (IRQ_MASK_EN only)
//   irq_valid   - a request is being presented
//   irq_id[2:0] - index of the presented request
//   pending     - registered pending-request vector
//   irq_timeout - one-cycle pulse after a presentation is abandoned
module irq_pending_ctrl #(
    parameter int ACK_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       ack,
`ifdef IRQ_MASK_EN
    input  logic [7:0] mask,
`endif
    output logic       irq_valid,
    output logic [2:0] irq_id,
    output logic [7:0] pending,
    output logic       irq_timeout
);
    typedef enum logic {IDLE, PRESENT} state_t;
    localparam bit         TO_EN = ACK_TIMEOUT != 0;
    localparam logic [7:0] LAST  = 8'(TO_EN ? ACK_TIMEOUT - 1 : 0);
    state_t     state, state_n;
    logic [7:0] cnt, cnt_n, eligible, pending_n;
    logic [2:0] id_n, top;
    logic       timeout_n;
`ifdef IRQ_MASK_EN
    assign eligible = pending & ~mask;
`else
    assign eligible = pending;
`endif
    // Later iterations override earlier ones, so the highest set bit wins.
    always_comb begin
        top = 3'd0;
        for (int i = 0; i < 8; i++)
            if (eligible[i]) top = 3'(i);
    end
    // Requests are OR-ed in after the ack clear so a same-cycle request survives.
    always_comb begin
        state_n   = state;
        id_n      = irq_id;
        cnt_n     = cnt;
        timeout_n = 1'b0;
        pending_n = pending | req;
        if (state == IDLE) begin
            if (eligible != 8'd0) begin
                state_n = PRESENT;
                id_n    = top;
                cnt_n   = 8'd0;
            end
        end else if (ack) begin
            state_n   = IDLE;
            pending_n = (pending & ~(8'd1 << irq_id)) | req;
        end else if (TO_EN && cnt == LAST) begin
            state_n   = IDLE;
            timeout_n = 1'b1;
        end else begin
            cnt_n = cnt + 8'd1;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            irq_id      <= 3'd0;
            cnt         <= 8'd0;
            pending     <= 8'd0;
            irq_timeout <= 1'b0;
        end else begin
            state       <= state_n;
            irq_id      <= id_n;
            cnt         <= cnt_n;
            pending     <= pending_n;
            irq_timeout <= timeout_n;
        end
    end
    assign irq_valid = state == PRESENT;
endmodule

// File: tb/tb_irq_pending_ctrl.sv
// tb_irq_pending_ctrl: checks two instances (timeout 4 and timeout disabled) against a behavioural model.
module tb_irq_pending_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = 8'd0;
    logic       ack = 1'b0;
    logic [7:0] mask = 8'd0;
    logic       v [2];
    logic [2:0] id [2];
    logic [7:0] pd [2];
    logic       to [2];
    int         n_cmp = 0;
    int         n_bad = 0;
    bit         started = 1'b0;
    logic [7:0] m_pend [2];
    bit         m_busy [2];
    int         m_id [2];
    int         m_age [2];
    bit         m_to [2];
    logic [7:0] el;
    int         t;

    always #5 clk = ~clk;

    irq_pending_ctrl #(.ACK_TIMEOUT(4)) u0 (
        .clk(clk), .rst_n(rst_n), .req(req), .ack(ack),
`ifdef IRQ_MASK_EN
        .mask(mask),
`endif
        .irq_valid(v[0]), .irq_id(id[0]), .pending(pd[0]), .irq_timeout(to[0])
    );
    irq_pending_ctrl #(.ACK_TIMEOUT(0)) u1 (
        .clk(clk), .rst_n(rst_n), .req(req), .ack(ack),
`ifdef IRQ_MASK_EN
        .mask(mask),
`endif
        .irq_valid(v[1]), .irq_id(id[1]), .pending(pd[1]), .irq_timeout(to[1])
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: one step per clock edge, straight from the request/ack/timeout rules.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            t = (k == 0) ? 4 : 0;
            if (!rst_n) begin
                m_pend[k] = 8'd0;
                m_busy[k] = 1'b0;
                m_id[k]   = 0;
                m_age[k]  = 0;
                m_to[k]   = 1'b0;
                started   = 1'b1;
            end else begin
`ifdef IRQ_MASK_EN
                el = m_pend[k] & ~mask;
`else
                el = m_pend[k];
`endif
                m_to[k] = 1'b0;
                if (m_busy[k]) begin
                    if (ack) begin
                        m_pend[k][m_id[k]] = 1'b0;
                        m_busy[k] = 1'b0;
                    end else if (t != 0 && m_age[k] + 1 == t) begin
                        m_busy[k] = 1'b0;
                        m_to[k]   = 1'b1;
                    end else begin
                        m_age[k]++;
                    end
                end else if (el != 8'd0) begin
                    m_busy[k] = 1'b1;
                    m_age[k]  = 0;
                    for (int b = 7; b >= 0; b--)
                        if (el[b]) begin
                            m_id[k] = b;
                            break;
                        end
                end
                m_pend[k] = m_pend[k] | req;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("u%0d.irq_valid", k), int'(v[k]), int'(m_busy[k]));
                if (m_busy[k]) chk($sformatf("u%0d.irq_id", k), int'(id[k]), m_id[k]);
                chk($sformatf("u%0d.pending", k), int'(pd[k]), int'(m_pend[k]));
                chk($sformatf("u%0d.irq_timeout", k), int'(to[k]), int'(m_to[k]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cnt;
        tick();
        tick();
        chk("reset_valid", int'(v[0]), 0);
        chk("reset_pending", int'(pd[0]), 0);
        chk("reset_id", int'(id[0]), 0);
        rst_n = 1'b1;
        tick();
        // single request, latency and ack
        req = 8'h01;
        tick();
        req = 8'h00;
        chk("lat_pending", int'(pd[0]), 8'h01);
        chk("lat_valid_c1", int'(v[0]), 0);
        tick();
        chk("lat_valid_c2", int'(v[0]), 1);
        chk("lat_id", int'(id[0]), 0);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("ack_pending", int'(pd[0]), 8'h00);
        chk("ack_valid", int'(v[0]), 0);
        tick();
        // priority between 7 and 2
        req = 8'h84;
        tick();
        req = 8'h00;
        tick();
        chk("prio_id7", int'(id[0]), 7);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("prio_pending", int'(pd[0]), 8'h04);
        chk("prio_idle_gap", int'(v[0]), 0);
        tick();
        chk("prio_valid2", int'(v[0]), 1);
        chk("prio_id2", int'(id[0]), 2);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        tick();
        // timeout after 4 presentation cycles
        req = 8'h10;
        tick();
        req = 8'h00;
        tick();
        cnt = 0;
        while (v[0] && cnt < 20) begin
            cnt++;
            tick();
        end
        chk("to_valid_cycles", cnt, 4);
        chk("to_pulse", int'(to[0]), 1);
        chk("to_pending_kept", int'(pd[0]), 8'h10);
        tick();
        chk("to_pulse_gone", int'(to[0]), 0);
        chk("to_represent", int'(v[0]), 1);
        chk("to_represent_id", int'(id[0]), 4);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        tick();
        // request and ack on the presented bit together
        req = 8'h08;
        tick();
        req = 8'h00;
        tick();
        chk("setwin_id", int'(id[0]), 3);
        req = 8'h08;
        ack = 1'b1;
        tick();
        req = 8'h00;
        ack = 1'b0;
        chk("setwin_pending", int'(pd[0]), 8'h08);
        tick();
        chk("setwin_again", int'(v[0]), 1);
        chk("setwin_again_id", int'(id[0]), 3);
        // reset mid-presentation with requests and ack ignored
        req = 8'hFF;
        tick();
        req = 8'h00;
        tick();
        rst_n = 1'b0;
        req = 8'hFF;
        ack = 1'b1;
        tick();
        req = 8'h00;
        ack = 1'b0;
        rst_n = 1'b1;
        chk("rst_valid", int'(v[0]), 0);
        chk("rst_pending", int'(pd[0]), 0);
        chk("rst_id", int'(id[0]), 0);
        chk("rst_timeout", int'(to[0]), 0);
        tick();
`ifdef IRQ_MASK_EN
        mask = 8'h80;
        req = 8'h81;
        tick();
        req = 8'h00;
        tick();
        chk("mask_id0", int'(id[0]), 0);
        mask = 8'h00;
        ack = 1'b1;
        tick();
        ack = 1'b0;
        tick();
        chk("mask_id7", int'(id[0]), 7);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        tick();
`endif
        for (int i = 0; i < 3000; i++) begin
            req = ($urandom_range(0, 3) == 0) ? 8'($urandom) & 8'($urandom) : 8'h00;
            ack = ($urandom_range(0, 2) == 0);
            rst_n = ($urandom_range(0, 99) != 0);
`ifdef IRQ_MASK_EN
            if ($urandom_range(0, 15) == 0) mask = 8'($urandom);
`endif
            tick();
        end
        rst_n = 1'b1;
        req = 8'h00;
        ack = 1'b0;
        tick();
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/irq_pending_ctrl.md
IRQ_PENDING_CTRL -- requirements
Module: irq_pending_ctrl

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, default 15, range 0..255: number of presentation cycles allowed without ack; 0 disables the timeout.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset: synchronous, active-low.
REQ-004 SHALL have port req, input, 8, request lines; bit i high in any sampled cycle raises request i.
REQ-005 SHALL have port ack, input, 1, consumer acknowledge of the presented request.
REQ-006 SHALL have port mask, input, 8, per-request disable (1 = masked); present only with IRQ_MASK_EN.
REQ-007 SHALL have port irq_valid, output, 1, a request is being presented.
REQ-008 SHALL have port irq_id, output, 3, index of the presented request; bit 7 = 3'b111, bit 0 = 3'b000.
REQ-009 SHALL have port pending, output, 8, registered pending-request vector.
REQ-010 SHALL have port irq_timeout, output, 1, one-cycle pulse when a presentation is abandoned.

Function
REQ-011 SHALL set pending[i] at the clock edge where req[i]=1 is sampled; pending bits clear only via REQ-016 or reset.
REQ-012 SHALL compute eligible = pending AND NOT mask (with IRQ_MASK_EN), else eligible = pending.
REQ-013 SHALL implement a two-state FSM, IDLE and PRESENT, with irq_valid=1 exactly in PRESENT.
REQ-014 SHALL, in IDLE with eligible nonzero, go to PRESENT and latch irq_id = index of the highest set eligible bit (bit 7 highest priority).
REQ-015 SHALL hold irq_id constant throughout PRESENT, even if higher-priority requests arrive or the presented bit becomes masked.
REQ-016 SHALL, in PRESENT with ack=1, clear pending[irq_id] and return to IDLE.
REQ-017 SHALL leave pending[irq_id] set if req[irq_id]=1 in the same cycle as the ack; set wins.
REQ-018 SHALL ignore ack while in IDLE.
REQ-019 SHALL keep an 8-bit wait counter: cleared on entry to PRESENT, incremented each PRESENT cycle without ack.
REQ-020 SHALL, when ACK_TIMEOUT != 0 and the counter equals ACK_TIMEOUT-1 with ack=0, return to IDLE, keep pending unchanged, and pulse irq_timeout for one cycle.
REQ-021 SHALL make irq_valid last exactly ACK_TIMEOUT cycles on timeout; ack in the last cycle wins over timeout.
REQ-022 SHALL give latency: req high in cycle 0 -> pending in cycle 1 -> irq_valid/irq_id in cycle 2 (FSM in IDLE).
REQ-023 SHALL spend at least one IDLE cycle between consecutive presentations.
REQ-024 SHALL drive all outputs from registers; no combinational path from inputs to outputs.

Reset
REQ-025 SHALL, at an edge with rst_n=0, set pending=0, state=IDLE, irq_valid=0, irq_id=3'b000, counter=0, irq_timeout=0.
REQ-026 SHALL ignore req and ack sampled while rst_n=0; reset mid-presentation drops it with no timeout pulse.

Configuration
REQ-027 SHALL use macro IRQ_MASK_EN: when defined, the mask port exists and masked bits still latch into pending but are never selected; when undefined, the mask port is absent and all bits are eligible.

Verification
REQ-028 SHALL cover: req=8'h01 for 1 cycle -> pending=8'h01 in cycle 1, irq_valid=1 and irq_id=0 in cycle 2; ack -> pending=8'h00 and irq_valid=0 in the next cycle.
REQ-029 SHALL cover: req=8'h84 together -> irq_id=7; ack -> pending=8'h04, one IDLE cycle, then irq_id=2.
REQ-030 SHALL cover: ACK_TIMEOUT=4, req=8'h10, no ack -> irq_valid high 4 cycles, irq_timeout pulse, pending=8'h10 kept, re-presented after 1 IDLE cycle.
REQ-031 SHALL cover: presenting id 3 with req[3]=1 and ack in the same cycle -> pending[3] stays 1 and id 3 is re-presented.
REQ-032 SHALL cover (IRQ_MASK_EN): mask=8'h80, req=8'h81 -> irq_id=0; clear mask -> after ack of 0, irq_id=7.
REQ-033 SHALL cover: rst_n=0 during PRESENT with pending=8'hFF -> next cycle all outputs zero, irq_timeout=0.
